// File: rtl/priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : priority_arbiter
// Description : 8-requester arbiter for one shared resource. Fixed (bit 0
//               highest) or rotating priority, grant held until done,
//               owner request drop, or a programmable hold limit.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       rr_en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] C_HOLD_LIMIT = 8'(HOLD_MAX);
  localparam logic       C_TIMEOUT_EN = (HOLD_MAX != 0);
  localparam logic [7:0] C_HOLD_SAT   = 8'hFF;

  state_t     r_state;
  logic       r_armed;
  logic [2:0] r_last;
  logic [7:0] r_hold_cnt;

  logic [2:0] w_fixed_id;
  logic [2:0] w_rr_id;
  logic [2:0] w_win_id;
  logic       w_rel_done;
  logic       w_rel_drop;
  logic       w_rel_limit;
  logic       w_release;

  // Fixed priority: scan downward so the lowest set index is the last hit.
  always_comb begin
    w_fixed_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) w_fixed_id = 3'(i);
    end
  end

  // Rotating priority: search last+1 .. last+8 (3-bit wrap), nearest hit wins.
  always_comb begin
    w_rr_id = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (req[r_last + 3'(k)]) w_rr_id = r_last + 3'(k);
    end
  end

  // Winner selection and release conditions for the current owner.
  always_comb begin
    w_win_id    = rr_en ? w_rr_id : w_fixed_id;
    w_rel_done  = done;
    w_rel_drop  = ~req[gnt_id];
    w_rel_limit = C_TIMEOUT_EN && (r_hold_cnt == C_HOLD_LIMIT);
    w_release   = w_rel_done | w_rel_drop | w_rel_limit;
  end

  // Arbitration FSM with registered outputs. Reset release is asynchronous to
  // clk, so the first edge after it only arms the arbiter; no grant is
  // launched from an edge that may sit inside the reset recovery window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b0;
      r_last     <= 3'd7;
      r_hold_cnt <= 8'd0;
      gnt        <= 8'd0;
      gnt_id     <= 3'd0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          timeout    <= 1'b0;
          r_hold_cnt <= 8'd0;
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (req != 8'd0) begin
            r_state    <= ST_GRANT;
            gnt        <= 8'd1 << w_win_id;
            gnt_id     <= w_win_id;
            gnt_valid  <= 1'b1;
            r_last     <= w_win_id;
            r_hold_cnt <= 8'd1;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state    <= ST_IDLE;
            gnt        <= 8'd0;
            gnt_id     <= 3'd0;
            gnt_valid  <= 1'b0;
            r_hold_cnt <= 8'd0;
            // Timeout is flagged only when the hold limit is the sole cause.
            timeout    <= w_rel_limit & ~w_rel_done & ~w_rel_drop;
          end else if (r_hold_cnt != C_HOLD_SAT) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_arbiter
// Description : Self-checking bench for priority_arbiter: vector table,
//               directed corner sequences and random stimulus against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       rr_en = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: owner index (-1 when idle), last grant, hold length.
  int m_owner;
  int m_last;
  int m_hold;
  bit m_timeout;
  bit m_armed;

  typedef struct {
    logic [7:0] req;
    logic [7:0] exp_gnt;
    logic [2:0] exp_id;
  } vec_t;

  vec_t vecs[6];

  priority_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .rr_en     (rr_en),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 7;
    m_hold    = 0;
    m_timeout = 1'b0;
    m_armed   = 1'b0;
  endtask

  // Priority order written out explicitly, then the first requester in it wins.
  function automatic int model_pick(input logic [7:0] r, input bit rr, input int last);
    int order[8];
    for (int k = 0; k < 8; k++) order[k] = rr ? (last + 1 + k) % 8 : k;
    for (int k = 0; k < 8; k++) if (r[order[k]]) return order[k];
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit by_done, by_drop, by_limit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_armed) begin
      m_armed = 1'b1;
      return;
    end
    if (m_owner < 0) begin
      m_timeout = 1'b0;
      if (req != 8'h00) begin
        m_owner = model_pick(req, rr_en, m_last);
        m_last  = m_owner;
        m_hold  = 1;
      end
    end else begin
      by_done  = done;
      by_drop  = !req[m_owner];
      by_limit = (HOLD != 0) && (m_hold == HOLD);
      if (by_done || by_drop || by_limit) begin
        m_timeout = by_limit && !by_done && !by_drop;
        m_owner   = -1;
        m_hold    = 0;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    check({tag, ".gnt"}, gnt, eg);
    check({tag, ".gnt_id"}, gnt_id, (m_owner >= 0) ? m_owner : 0);
    check({tag, ".gnt_valid"}, gnt_valid, (m_owner >= 0) ? 1 : 0);
    check({tag, ".timeout"}, timeout, m_timeout);
    check({tag, ".onehot0"}, $onehot0(gnt), 1);
    if (gnt_valid) check({tag, ".gnt_vs_id"}, gnt, 8'd1 << gnt_id);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    tick("rst_pulse");
    rst_n = 1'b1;
    tick("rst_arm");
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'b1010_0100, 8'h04, 3'd2};
    vecs[1] = '{8'h80,        8'h80, 3'd7};
    vecs[2] = '{8'h01,        8'h01, 3'd0};
    vecs[3] = '{8'hFF,        8'h01, 3'd0};
    vecs[4] = '{8'h60,        8'h20, 3'd5};
    vecs[5] = '{8'h18,        8'h08, 3'd3};

    model_reset();

    // Reset state, then release with req=08: first edge arms, second grants.
    tick("reset");
    tick("reset");
    rst_n = 1'b1;
    req   = 8'h08;
    tick("arm");
    check("arm_no_grant", gnt_valid, 0);
    tick("first");
    check("first_gnt", gnt, 8'h08);
    check("first_id", gnt_id, 3);

    // Asynchronous reset mid-grant clears outputs before any edge.
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_gnt", gnt, 0);
    check("async_id", gnt_id, 0);
    check("async_valid", gnt_valid, 0);
    check("async_timeout", timeout, 0);
    req = 8'h00;
    tick("in_reset");
    rst_n = 1'b1;
    tick("rearm");

    // Table of fixed-priority winners, each from IDLE, released by request drop.
    rr_en = 1'b0;
    foreach (vecs[i]) begin
      req = vecs[i].req;
      tick("tbl");
      check("tbl_gnt", gnt, vecs[i].exp_gnt);
      check("tbl_id", gnt_id, vecs[i].exp_id);
      req = 8'h00;
      tick("tbl_rel");
      check("tbl_idle", gnt_valid, 0);
    end

    // Fixed priority sequence: id 2, done at cycle 3, idle at 4, id 5 at 5.
    req = 8'b1010_0100;
    tick("fix_c1");
    check("fix_c1_gnt", gnt, 8'h04);
    tick("fix_c2");
    tick("fix_c3");
    done = 1'b1;
    tick("fix_c4");
    check("fix_c4_gnt", gnt, 8'h00);
    done = 1'b0;
    req  = 8'b1010_0000;
    tick("fix_c5");
    check("fix_c5_gnt", gnt, 8'h20);
    check("fix_c5_id", gnt_id, 5);
    req = 8'h00;
    tick("fix_end");

    // Rotating priority from a fresh reset: ids 0..7 then 0.
    rr_en = 1'b1;
    reset_pulse();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick("rr_gnt");
      check("rr_id", gnt_id, i % 8);
      check("rr_valid", gnt_valid, 1);
      done = 1'b1;
      tick("rr_idle");
      check("rr_idle_valid", gnt_valid, 0);
      done = 1'b0;
    end
    req   = 8'h00;
    rr_en = 1'b0;
    tick("rr_end");

    // Hold-limit timeout: grant cycles 1-4, timeout in 5, regrant in 6.
    req = 8'h01;
    for (int c = 1; c <= 4; c++) begin
      tick("to_hold");
      check("to_hold_valid", gnt_valid, 1);
    end
    tick("to_c5");
    check("to_c5_gnt", gnt, 0);
    check("to_c5_timeout", timeout, 1);
    tick("to_c6");
    check("to_c6_id", gnt_id, 0);
    check("to_c6_valid", gnt_valid, 1);
    check("to_c6_timeout", timeout, 0);

    // done coinciding with the limit: release without timeout.
    tick("sim_c2");
    tick("sim_c3");
    tick("sim_c4");
    done = 1'b1;
    tick("sim_rel");
    check("sim_rel_valid", gnt_valid, 0);
    check("sim_rel_timeout", timeout, 0);
    done = 1'b0;
    req  = 8'h00;
    tick("sim_end");

    // Owner drops request in grant cycle 2 while req[6] is pending.
    req = 8'h41;
    tick("drop_c1");
    check("drop_c1_id", gnt_id, 0);
    tick("drop_c2");
    req = 8'h40;
    tick("drop_c3");
    check("drop_c3_valid", gnt_valid, 0);
    tick("drop_c4");
    check("drop_c4_id", gnt_id, 6);
    check("drop_c4_valid", gnt_valid, 1);
    req = 8'h00;
    tick("drop_rel");
    tick("drop_end");

    // done pulsed in IDLE is ignored.
    done = 1'b1;
    tick("idle_done");
    check("idle_done_valid", gnt_valid, 0);
    check("idle_done_timeout", timeout, 0);
    done = 1'b0;
    tick("idle_done_end");

    // Random stimulus against the reference model, with occasional async reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) rr_en = ~rr_en;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rnd_async");
      end else if (!rst_n) begin
        rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/priority_arbiter.md
# priority_arbiter

Sequential 8-requester arbiter that shares one resource using the team's 8-to-3 priority encoding convention: bit 0 has the highest priority and the lowest index wins. A grant is held until the owner signals `done`, drops its request, or exceeds a programmable hold limit. A run-time mode bit selects fixed priority or rotating (round-robin) priority. The arbiter sits between the request lines of up to eight clients and the shared datapath. The datapath uses `gnt_id` as its 3-bit select.

## Interface
- `HOLD_MAX`, default 15: maximum number of cycles a grant may be held, range 1..255. A value of 0 disables the timeout.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request lines, one per client; level-sensitive.
- `done`  in  1  owner finished; meaningful only while `gnt_valid`=1.
- `rr_en`  in  1  1 = rotating priority, 0 = fixed priority (bit 0 highest).
- `gnt`  out  8  one-hot grant; all zero when idle.
- `gnt_id`  out  3  binary index of the granted client; 0 when idle.
- `gnt_valid`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- All outputs are registered.
- Two states:
  - IDLE: `gnt`=0, `gnt_valid`=0, `gnt_id`=0.
  - GRANT: exactly one `gnt` bit is set.
- IDLE -> GRANT when `req`≠0.
  - The winner is computed from `req` and `rr_en` sampled in this IDLE cycle.
  - The grant appears on the next edge.
- IDLE with `req`=0 stays in IDLE.
- Fixed mode (`rr_en`=0): the lowest set index wins.
  - Example: `req`=8'b1010_0100 gives id 2.
- Rotating mode (`rr_en`=1): search order is `last`+1, `last`+2, …, `last`, modulo 8 with 3-bit wrap.
  - `last` is the id of the most recent grant. It is updated on entry to GRANT, in both modes.
  - `last` resets to 7, so the first search after reset starts at 0.
- GRANT -> IDLE on the first cycle in which any release condition holds. Release conditions, in priority order:
  - (a) `done`=1;
  - (b) `req[gnt_id]`=0;
  - (c) `hold_cnt`==`HOLD_MAX` with `HOLD_MAX`≠0.
- While in GRANT, requests from non-owners are ignored and `rr_en` changes have no effect.
- `hold_cnt` (8 bits) counts cycles in GRANT.
  - It is 1 in the first grant cycle and increments each grant cycle.
  - It is cleared in IDLE and never wraps.
- `timeout` is asserted for one cycle, in the IDLE cycle that follows a release caused only by (c).
  - If `done` or the owner's request drop coincides with the limit, the release is attributed to (a) or (b) and `timeout` stays 0.
- `done` asserted in IDLE is ignored.
- A timed-out client keeps its request pending and competes normally.
  - In fixed mode it may win again immediately.
  - In rotating mode it goes to the back of the order.

## Timing
- Reset (asynchronous, any time, including mid-grant): all outputs are 0, state is IDLE, `hold_cnt`=0, `last`=7.
  - The first grant may appear at the second rising edge after `rst_n` rises, if `req`≠0.
- Request-to-grant latency: 1 cycle from the IDLE cycle in which `req` is sampled.
- Release latency: the release condition is seen in cycle R; `gnt` is 0 in cycle R+1 (IDLE); the next grant can appear in cycle R+2.
  - There is always at least one idle cycle between consecutive grants.
- Maximum grant length: `HOLD_MAX` cycles.
- `gnt`, `gnt_id` and `gnt_valid` stay stable for the whole grant.
- Invariant checked every cycle: `gnt` is one-hot or zero, and when `gnt_valid`=1, `gnt`==1<<`gnt_id`.

## Test plan
- Reset and idle:
  - Assert `rst_n`=0 mid-grant -> `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0 immediately, without waiting for a clock edge.
  - Release reset with `req`=8'h08 -> grant id 3 two edges later.
- Fixed priority, `rr_en`=0:
  - `req`=8'b1010_0100 at cycle 0 -> `gnt`=8'h04, id 2 at cycle 1.
  - `done` at cycle 3 -> `gnt`=0 at cycle 4.
  - `gnt`=8'h20, id 5 at cycle 5.
- Rotating priority, `rr_en`=1:
  - `req`=8'hFF held, `done` pulsed in every grant cycle -> ids 0,1,2,…,7,0.
  - Each grant lasts 1 cycle, separated by 1 idle cycle.
- Timeout, `HOLD_MAX`=4:
  - `req`=8'h01 held, no `done` -> `gnt_valid`=1 in cycles 1–4.
  - Cycle 5: `gnt`=0 and `timeout`=1.
  - Cycle 6: regrant to id 0.
- Simultaneous events, `HOLD_MAX`=4:
  - `done`=1 in grant cycle 4 -> release in cycle 5 with `timeout`=0.
- Owner request drop:
  - Owner drops its `req` in grant cycle 2 while `req[6]` is pending -> idle in cycle 3, id 6 granted in cycle 4.
- Ignored `done`:
  - `done` pulsed in IDLE -> no state change.
